// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI slave register interface.
package spi_pkg;

  localparam int unsigned CMD_WIDTH_DEF = 8;

  // Frames are writes when the MSB of the command word is set.
  function automatic int unsigned cmd_wr_bit(input int unsigned cmd_width);
    return cmd_width - 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/spi_slave_if_if.sv
// SPI pin and register-side bundle for the SPI slave register interface.
interface spi_slave_if_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 4
) ();

  logic                  spi_cs_n;
  logic                  spi_sclk;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic                  cmd_flag;
  logic [SEL_WIDTH-1:0]  dcmd;
  logic                  data_flag;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  busy;
  logic                  frame_err;

  // SPI master plus register file side.
  modport master (
    output spi_cs_n, spi_sclk, spi_mosi, dout,
    input  spi_miso, cmd_flag, dcmd, data_flag, din, busy, frame_err
  );

  modport slave (
    input  spi_cs_n, spi_sclk, spi_mosi, dout,
    output spi_miso, cmd_flag, dcmd, data_flag, din, busy, frame_err
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with registered rise/fall detection on the synchronized level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  // [1:0] is the synchronizer, [2] the previous synchronized level.
  logic [2:0] sync_q;
  logic       rise_q;
  logic       fall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {3{RST_VAL}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
      rise_q <= sync_q[1] & ~sync_q[2];
      fall_q <= ~sync_q[1] & sync_q[2];
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: command byte selects a register, then a data word is written or read.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH     = 32,
  parameter  int unsigned CHANNEL_NUMBER = 16,
  parameter  int unsigned CMD_WIDTH      = CMD_WIDTH_DEF,
  localparam int unsigned SEL_WIDTH      = $clog2(CHANNEL_NUMBER)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_cs_n,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  cmd_flag,
  output logic [SEL_WIDTH-1:0]  dcmd,
  output logic                  data_flag,
  output logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int unsigned MAX_BITS = (DATA_WIDTH > CMD_WIDTH) ? DATA_WIDTH : CMD_WIDTH;
  localparam int unsigned CNT_W    = $clog2(MAX_BITS);
  localparam int unsigned WR_BIT   = cmd_wr_bit(CMD_WIDTH);
  localparam int unsigned SETTLE_W = 3;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk_i (clk), .rst_i (rst), .async_i (spi_sclk),
    .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk_i (clk), .rst_i (rst), .async_i (spi_cs_n),
    .rise_o(cs_rise), .fall_o(cs_fall)
  );

  logic [1:0]          mosi_sync_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                stale_q;
  logic                settled;
  logic                armed;

  assign settled = &settle_q;
  assign armed   = settled & ~stale_q;

  // A cs_n fall seen while the synchronizer settles after reset belongs to a frame
  // already in flight; stay disarmed until cs_n has been seen high again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_sync_q <= 2'b00;
      settle_q    <= '0;
      stale_q     <= 1'b0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      if (!settled) settle_q <= settle_q + SETTLE_W'(1);
      if (cs_rise)                  stale_q <= 1'b0;
      else if (cs_fall && !settled) stale_q <= 1'b1;
    end
  end

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CMD_WIDTH-2:0]  cmd_sr_q;
  logic [DATA_WIDTH-2:0] rx_sr_q;
  logic [DATA_WIDTH-2:0] tx_sr_q;
  logic                  tx_loaded_q;
  logic                  write_en_q;
  logic                  miso_q;
  logic                  cmd_flag_q;
  logic [SEL_WIDTH-1:0]  dcmd_q;
  logic                  data_flag_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  busy_q;
  logic                  frame_err_q;

  logic [CMD_WIDTH-1:0]  cmd_next;
  logic [DATA_WIDTH-1:0] rx_next;

  assign cmd_next = {cmd_sr_q, mosi_sync_q[1]};
  assign rx_next  = {rx_sr_q, mosi_sync_q[1]};

  // Frame FSM; miso_q holds the current TX bit, tx_sr_q the bits still to send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_sr_q    <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      tx_loaded_q <= 1'b0;
      write_en_q  <= 1'b0;
      miso_q      <= 1'b0;
      cmd_flag_q  <= 1'b0;
      dcmd_q      <= '0;
      data_flag_q <= 1'b0;
      din_q       <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cmd_flag_q  <= 1'b0;
      data_flag_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          miso_q <= 1'b0;
          busy_q <= 1'b0;
          if (cs_fall && armed) begin
            state_q  <= ST_CMD;
            cnt_q    <= '0;
            cmd_sr_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        ST_CMD: begin
          miso_q <= 1'b0;
          if (cs_rise) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
          end else if (sclk_rise) begin
            cmd_sr_q <= cmd_next[CMD_WIDTH-2:0];
            if (cnt_q == CNT_W'(CMD_WIDTH - 1)) begin
              state_q     <= ST_DATA;
              cnt_q       <= '0;
              cmd_flag_q  <= 1'b1;
              dcmd_q      <= cmd_next[SEL_WIDTH-1:0];
              write_en_q  <= cmd_next[WR_BIT];
              tx_loaded_q <= 1'b0;
              rx_sr_q     <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (cs_rise) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b1;
          end else begin
            if (sclk_fall) begin
              tx_loaded_q <= 1'b1;
              if (!tx_loaded_q) begin
                miso_q  <= dout[DATA_WIDTH-1];
                tx_sr_q <= dout[DATA_WIDTH-2:0];
              end else begin
                miso_q  <= tx_sr_q[DATA_WIDTH-2];
                tx_sr_q <= {tx_sr_q[DATA_WIDTH-3:0], 1'b0};
              end
            end
            if (sclk_rise) begin
              rx_sr_q <= rx_next[DATA_WIDTH-2:0];
              if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                state_q     <= ST_DONE;
                din_q       <= rx_next;
                data_flag_q <= write_en_q;
                miso_q      <= 1'b0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
        end
        ST_DONE: begin
          miso_q <= 1'b0;
          if (cs_rise) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          miso_q  <= 1'b0;
        end
      endcase
    end
  end

  assign spi_miso  = miso_q;
  assign cmd_flag  = cmd_flag_q;
  assign dcmd      = dcmd_q;
  assign data_flag = data_flag_q;
  assign din       = din_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: a bit-banged SPI master with a scoreboard of expected flags.
module tb_spi_slave_if;

  localparam int unsigned DW       = 32;
  localparam int unsigned CN       = 16;
  localparam int unsigned SW       = 4;
  localparam int          HALF     = 10;
  localparam int          HALF_MIN = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_if_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

  spi_slave_if #(.DATA_WIDTH(DW), .CHANNEL_NUMBER(CN), .CMD_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_cs_n (bus.spi_cs_n),
    .spi_sclk (bus.spi_sclk),
    .spi_mosi (bus.spi_mosi),
    .spi_miso (bus.spi_miso),
    .cmd_flag (bus.cmd_flag),
    .dcmd     (bus.dcmd),
    .data_flag(bus.data_flag),
    .din      (bus.din),
    .dout     (bus.dout),
    .busy     (bus.busy),
    .frame_err(bus.frame_err)
  );

  logic [DW-1:0] mem [CN];
  assign bus.dout = mem[bus.dcmd];

  int checks = 0;
  int errors = 0;
  int cmd_seen = 0;
  int data_seen = 0;
  int ferr_seen = 0;

  logic [SW-1:0] exp_cmd_q [$];
  logic [DW-1:0] exp_data_q[$];
  logic [SW-1:0] mon_cmd;
  logic [DW-1:0] mon_data;

  // Scoreboard monitor: every flag pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.cmd_flag === 1'b1) begin
        cmd_seen++;
        checks++;
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_flag_unexpected: dcmd=%0d, no cmd_flag expected", bus.dcmd);
        end else begin
          mon_cmd = exp_cmd_q.pop_front();
          if (bus.dcmd !== mon_cmd) begin
            errors++;
            $display("FAIL dcmd: got %0d, expected %0d", bus.dcmd, mon_cmd);
          end
        end
      end
      if (bus.data_flag === 1'b1) begin
        data_seen++;
        checks++;
        if (exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL data_flag_unexpected: din=%h, no data_flag expected", bus.din);
        end else begin
          mon_data = exp_data_q.pop_front();
          if (bus.din !== mon_data) begin
            errors++;
            $display("FAIL din: got %h, expected %h", bus.din, mon_data);
          end
        end
      end
      if (bus.frame_err === 1'b1) ferr_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_bit(input logic mosi_v, input int half, output logic miso_v);
    bus.spi_mosi = mosi_v;
    wait_clk(half);
    miso_v = bus.spi_miso;
    bus.spi_sclk = 1'b1;
    wait_clk(half);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic shift_word(input logic [DW-1:0] w, input int n, input int half,
                            output logic [DW-1:0] rd);
    logic b;
    rd = '0;
    for (int i = 0; i < n; i++) begin
      sclk_bit(w[DW-1-i], half, b);
      rd = {rd[DW-2:0], b};
    end
  endtask

  task automatic push_frame(input logic [7:0] cmd, input logic [DW-1:0] data);
    exp_cmd_q.push_back(cmd[SW-1:0]);
    if (cmd[7]) exp_data_q.push_back(data);
  endtask

  task automatic full_frame(input logic [7:0] cmd, input logic [DW-1:0] data,
                            input int half, input int gap, output logic [DW-1:0] rd);
    logic [DW-1:0] dummy;
    bus.spi_cs_n = 1'b0;
    wait_clk(half);
    shift_word({cmd, 24'h0}, 8, half, dummy);
    shift_word(data, DW, half, rd);
    wait_clk(half);
    bus.spi_cs_n = 1'b1;
    wait_clk(gap);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.spi_cs_n = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    wait_clk(5);
    checks++; if (bus.cmd_flag  !== 1'b0) begin errors++; $display("FAIL rst_cmd_flag: got %b, expected 0", bus.cmd_flag); end
    checks++; if (bus.data_flag !== 1'b0) begin errors++; $display("FAIL rst_data_flag: got %b, expected 0", bus.data_flag); end
    checks++; if (bus.dcmd      !== '0)   begin errors++; $display("FAIL rst_dcmd: got %h, expected 0", bus.dcmd); end
    checks++; if (bus.din       !== '0)   begin errors++; $display("FAIL rst_din: got %h, expected 0", bus.din); end
    checks++; if (bus.spi_miso  !== 1'b0) begin errors++; $display("FAIL rst_miso: got %b, expected 0", bus.spi_miso); end
    checks++; if (bus.busy      !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", bus.busy); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b, expected 0", bus.frame_err); end
    rst = 1'b0;
    wait_clk(20);
  endtask

  task automatic test_write;
    int c0 = cmd_seen, d0 = data_seen, f0 = ferr_seen;
    logic [DW-1:0] rd;
    push_frame(8'h83, 32'hDEADBEEF);
    full_frame(8'h83, 32'hDEADBEEF, HALF, 2 * HALF, rd);
    checks++; if (cmd_seen - c0 !== 1) begin errors++; $display("FAIL write_cmd_count: got %0d, expected 1", cmd_seen - c0); end
    checks++; if (data_seen - d0 !== 1) begin errors++; $display("FAIL write_data_count: got %0d, expected 1", data_seen - d0); end
    checks++; if (ferr_seen - f0 !== 0) begin errors++; $display("FAIL write_frame_err: got %0d, expected 0", ferr_seen - f0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL write_busy_after: got %b, expected 0", bus.busy); end
  endtask

  task automatic test_read;
    int d0 = data_seen;
    logic [DW-1:0] rd;
    mem[5] = 32'h12345678;
    push_frame(8'h05, 32'hA5A55A5A);
    full_frame(8'h05, 32'hA5A55A5A, HALF, 2 * HALF, rd);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL read_miso_word: got %h, expected %h", rd, 32'h12345678); end
    checks++; if (data_seen - d0 !== 0) begin errors++; $display("FAIL read_data_flag: got %0d pulses, expected 0", data_seen - d0); end
    checks++; if (bus.din !== 32'hA5A55A5A) begin errors++; $display("FAIL read_din: got %h, expected %h", bus.din, 32'hA5A55A5A); end
  endtask

  task automatic test_abort;
    int d0 = data_seen, f0 = ferr_seen;
    logic [DW-1:0] rd;
    exp_cmd_q.push_back(4'h1);
    bus.spi_cs_n = 1'b0;
    wait_clk(HALF);
    shift_word({8'h81, 24'h0}, 8, HALF, rd);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_in_data: got %b, expected 1", bus.busy); end
    shift_word(32'hFFFF_FFFF, 20, HALF, rd);
    wait_clk(HALF);
    bus.spi_cs_n = 1'b1;
    wait_clk(2 * HALF);
    checks++; if (ferr_seen - f0 !== 1) begin errors++; $display("FAIL abort_frame_err: got %0d pulses, expected 1", ferr_seen - f0); end
    checks++; if (data_seen - d0 !== 0) begin errors++; $display("FAIL abort_data_flag: got %0d pulses, expected 0", data_seen - d0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, expected 0", bus.busy); end
  endtask

  task automatic test_extra_sclk;
    int d0 = data_seen;
    logic [DW-1:0] rd;
    logic b;
    logic miso_or = 1'b0;
    push_frame(8'h82, 32'hCAFEF00D);
    bus.spi_cs_n = 1'b0;
    wait_clk(HALF);
    shift_word({8'h82, 24'h0}, 8, HALF, rd);
    shift_word(32'hCAFEF00D, DW, HALF, rd);
    for (int i = 0; i < 40; i++) begin
      sclk_bit(i[0], HALF, b);
      miso_or = miso_or | b;
    end
    checks++; if (miso_or !== 1'b0) begin errors++; $display("FAIL done_miso: got %b, expected 0", miso_or); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL done_busy: got %b, expected 1", bus.busy); end
    wait_clk(HALF);
    bus.spi_cs_n = 1'b1;
    wait_clk(2 * HALF);
    checks++; if (data_seen - d0 !== 1) begin errors++; $display("FAIL extra_sclk_data_count: got %0d, expected 1", data_seen - d0); end
  endtask

  task automatic test_reset_mid;
    int c0 = cmd_seen, d0 = data_seen, f0 = ferr_seen;
    logic [DW-1:0] rd;
    exp_cmd_q.push_back(4'h4);
    bus.spi_cs_n = 1'b0;
    wait_clk(HALF);
    shift_word({8'h84, 24'h0}, 8, HALF, rd);
    shift_word(32'hFFFF_FFFF, 10, HALF, rd);
    rst = 1'b1;
    wait_clk(4);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, expected 0", bus.busy); end
    rst = 1'b0;
    shift_word(32'hFFFF_FFFF, DW, HALF, rd);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_ignored_busy: got %b, expected 0", bus.busy); end
    wait_clk(HALF);
    bus.spi_cs_n = 1'b1;
    wait_clk(2 * HALF);
    checks++; if (cmd_seen - c0 !== 1) begin errors++; $display("FAIL midrst_cmd_count: got %0d, expected 1", cmd_seen - c0); end
    checks++; if (data_seen - d0 !== 0) begin errors++; $display("FAIL midrst_data_count: got %0d, expected 0", data_seen - d0); end
    checks++; if (ferr_seen - f0 !== 0) begin errors++; $display("FAIL midrst_frame_err: got %0d, expected 0", ferr_seen - f0); end
    push_frame(8'h8F, 32'h0000_0001);
    full_frame(8'h8F, 32'h0000_0001, HALF, 2 * HALF, rd);
    checks++; if (cmd_seen - c0 !== 2) begin errors++; $display("FAIL midrst_next_cmd: got %0d, expected 2", cmd_seen - c0); end
    checks++; if (data_seen - d0 !== 1) begin errors++; $display("FAIL midrst_next_data: got %0d, expected 1", data_seen - d0); end
  endtask

  task automatic test_back_to_back;
    int c0 = cmd_seen, d0 = data_seen, f0 = ferr_seen;
    logic [DW-1:0] rd;
    push_frame(8'h81, 32'h1111_1111);
    push_frame(8'h8A, 32'h0F0F_0F0F);
    full_frame(8'h81, 32'h1111_1111, HALF_MIN, 4 * HALF_MIN, rd);
    full_frame(8'h8A, 32'h0F0F_0F0F, HALF_MIN, 4 * HALF_MIN, rd);
    checks++; if (cmd_seen - c0 !== 2) begin errors++; $display("FAIL b2b_cmd_count: got %0d, expected 2", cmd_seen - c0); end
    checks++; if (data_seen - d0 !== 2) begin errors++; $display("FAIL b2b_data_count: got %0d, expected 2", data_seen - d0); end
    checks++; if (ferr_seen - f0 !== 0) begin errors++; $display("FAIL b2b_frame_err: got %0d, expected 0", ferr_seen - f0); end
  endtask

  initial begin
    for (int i = 0; i < int'(CN); i++) mem[i] = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_extra_sclk();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_cmd_q.size() != 0 || exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d cmd and %0d data pending, expected 0",
               exp_cmd_q.size(), exp_data_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
SPI_SLAVE_IF -- requirements
Module: spi_slave_if

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data word width in bits.
REQ-002 Parameter CHANNEL_NUMBER, default 16, SHALL set the register count; SEL_WIDTH = $clog2(CHANNEL_NUMBER).
REQ-003 Parameter CMD_WIDTH, default 8, SHALL set the command phase length in bits.
REQ-004 Ports SHALL be (name direction width meaning):
 clk  in  1  single system clock; all logic on its rising edge
 rst  in  1  asynchronous, active-high reset
 spi_cs_n  in  1  SPI chip select, active low, asynchronous to clk
 spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
 spi_mosi  in  1  master-out data, MSB first
 spi_miso  out  1  slave-out data, MSB first
 cmd_flag  out  1  one-clk pulse; dcmd valid
 dcmd  out  SEL_WIDTH  register address from the command byte
 data_flag  out  1  one-clk pulse; din valid (write frames only)
 din  out  DATA_WIDTH  received data word
 dout  in  DATA_WIDTH  read word for the latched address; valid 2 clk after cmd_flag
 busy  out  1  high while a frame is in progress
 frame_err  out  1  one-clk pulse on a truncated frame

Function
REQ-005 spi_cs_n, spi_sclk and spi_mosi SHALL each pass through a 2-FF synchronizer; sclk rise/fall and cs_n fall/rise SHALL be edge-detected after synchronization.
REQ-006 Supported operation SHALL require clk frequency >= 16x spi_sclk frequency.
REQ-007 The FSM SHALL have states IDLE, CMD, DATA and DONE.
REQ-008 IDLE->CMD SHALL occur only on a synchronized cs_n falling edge; the bit counter SHALL clear to 0 on entry.
REQ-009 In CMD, each sclk rising edge SHALL shift mosi into the command shift register (MSB first) and increment the bit counter.
REQ-010 On the CMD_WIDTH-th rising edge, the block SHALL pulse cmd_flag for 1 clk, with dcmd = cmd[SEL_WIDTH-1:0], latch write_en = cmd[CMD_WIDTH-1], and enter DATA; remaining command bits SHALL be ignored.
REQ-011 On the first sclk falling edge in DATA, the TX shift register SHALL load dout and drive spi_miso with dout[DATA_WIDTH-1]; each later falling edge SHALL shift left by one bit.
REQ-012 In DATA, each rising edge SHALL shift mosi into the RX shift register; on the DATA_WIDTH-th rising edge, din SHALL update to the received word and the FSM SHALL enter DONE.
REQ-013 data_flag SHALL pulse for 1 clk, in the same cycle din updates, only if write_en=1; read frames SHALL update din but SHALL NOT pulse data_flag.
REQ-014 In DONE, sclk edges SHALL be ignored and spi_miso SHALL be held 0 until a cs_n rising edge, which SHALL return the FSM to IDLE.
REQ-015 A cs_n rising edge in CMD or DATA SHALL abort the frame: FSM->IDLE, frame_err pulses for 1 clk, and no cmd_flag or data_flag is issued for the remainder of that frame.
REQ-016 spi_miso SHALL be 0 in IDLE, in CMD, and in DONE.
REQ-017 busy SHALL be 1 in CMD, DATA and DONE, and 0 in IDLE.
REQ-018 A cs_n falling edge while not in IDLE SHALL be ignored.

Reset
REQ-019 While rst=1, the FSM SHALL be in IDLE, all counters and shift registers SHALL be 0, and cmd_flag, data_flag, dcmd, din, spi_miso, busy and frame_err SHALL all be 0.
REQ-020 The synchronizer flops SHALL reset to idle bus levels: cs_n=1, sclk=0, mosi=0.
REQ-021 After rst deasserts mid-frame with cs_n still low, the block SHALL ignore that frame and wait for the next cs_n falling edge.

Structure
REQ-022 Package spi_pkg SHALL hold the CMD_WIDTH default, the write-bit position and the FSM state encoding.
REQ-023 Sub-module spi_sync_edge (2-FF synchronizer plus rise/fall detect, reset value as a parameter) SHALL be instantiated for spi_sclk and spi_cs_n.

Verification
REQ-024 Write frame, cmd 0x83, data 0xDEADBEEF -> cmd_flag once with dcmd=3; data_flag once with din=0xDEADBEEF.
REQ-025 Read frame, cmd 0x05, dout model returns 0x12345678 for address 5 -> MISO bits during DATA = 0x12345678; data_flag never pulses.
REQ-026 cs_n deasserted after 20 DATA bits of a write frame -> frame_err pulses once, no data_flag, busy=0 after the sync delay.
REQ-027 40 extra sclk cycles after a complete write frame -> exactly one data_flag; spi_miso stays 0 in DONE.
REQ-028 rst asserted mid-DATA, released with cs_n low, then 32 more sclk cycles -> no flags; the next full frame (cmd 0x8F, data 0x00000001) decodes correctly with dcmd=15.
REQ-029 Back-to-back frames with 2 sclk periods of cs_n high, at the minimum 16:1 clk:sclk ratio -> both frames decoded with no frame_err.
